// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and field geometry for the one-line cache miss controller and its array.
package cache_ctrl_fsm_pkg;

   localparam int OFFSET_W   = 3;
   localparam int INDEX_W    = 7;
   localparam int BYTE_OFF_W = 2;
   localparam int TAG_W      = 32 - BYTE_OFF_W - OFFSET_W - INDEX_W;
   localparam int DATA_W     = 32;
   localparam int BLOCK_W    = (1 << OFFSET_W) * DATA_W;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      REFILL,
      INSTALL,
      REPLAY
   } state_e;

   typedef struct packed {
      logic enable;
      logic cmp;
      logic write;
      logic valid_in;
      logic mem_req;
      logic mem_we;
   } ctrl_t;

   // Array and memory strobes for a state; registered on entry so they are glitch-free.
   function automatic ctrl_t ctrl_for(state_e st, logic we);
      ctrl_t c;
      c = '0;
      case (st)
         COMPARE, REPLAY: begin
            c.enable = 1'b1;
            c.cmp    = 1'b1;
            c.write  = we;
         end
         WRITEBACK: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
         end
         REFILL: c.mem_req = 1'b1;
         INSTALL: begin
            c.enable   = 1'b1;
            c.write    = 1'b1;
            c.valid_in = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cache_ctrl_perf.sv
// Hit and miss performance counters; each wraps silently on overflow.
module cache_ctrl_perf #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hit_inc_i,
   input  logic                 miss_inc_i,
   output logic [CNT_WIDTH-1:0] hit_cnt_o,
   output logic [CNT_WIDTH-1:0] miss_cnt_o
);

   logic [CNT_WIDTH-1:0] hit_q;
   logic [CNT_WIDTH-1:0] miss_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit_inc_i)  hit_q  <= hit_q + CNT_WIDTH'(1);
         if (miss_inc_i) miss_q <= miss_q + CNT_WIDTH'(1);
      end
   end

   assign hit_cnt_o  = hit_q;
   assign miss_cnt_o = miss_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller for a direct-mapped cache: lookup, dirty write-back,
// block refill, install and replay of a single outstanding CPU word access.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for cpu_req; request fields latched on acceptance
//   COMPARE   | tag lookup; hit completes, miss picks write-back or refill
//   WRITEBACK | dirty victim block sent to memory, held until mem_ack
//   REFILL    | block read from memory, captured into fill buffer on mem_ack
//   INSTALL   | one cycle: fill block written to the array, line made valid
//   REPLAY    | repeat of the lookup on the fresh line; completes the access
module cache_ctrl_fsm
   import cache_ctrl_fsm_pkg::*;
#(
   parameter int OFFSET_WIDTH = OFFSET_W,
   parameter int INDEX_WIDTH  = INDEX_W,
   parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
   parameter int DATA_WIDTH   = DATA_W,
   parameter int BLOCK_WIDTH  = (1 << OFFSET_WIDTH) * DATA_WIDTH,
   parameter int CNT_WIDTH    = CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [31:0]             cpu_addr,
   input  logic [3:0]              cpu_byte_en,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    cpu_ready,
   output logic                    line_enable,
   output logic                    line_cmp,
   output logic                    line_write,
   output logic                    line_valid_in,
   output logic [3:0]              line_byte_w_en,
   output logic [TAG_WIDTH-1:0]    line_tag,
   output logic [INDEX_WIDTH-1:0]  line_index,
   output logic [OFFSET_WIDTH-1:0] line_word_sel,
   output logic [DATA_WIDTH-1:0]   line_data_in,
   output logic [BLOCK_WIDTH-1:0]  line_block_in,
   input  logic                    line_hit,
   input  logic                    line_dirty,
   input  logic                    line_valid,
   input  logic [TAG_WIDTH-1:0]    line_tag_out,
   input  logic [DATA_WIDTH-1:0]   line_data_out,
   input  logic [BLOCK_WIDTH-1:0]  line_data_wb,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [BLOCK_WIDTH-1:0]  mem_wdata,
   input  logic [BLOCK_WIDTH-1:0]  mem_rdata,
   input  logic                    mem_ack,
   output logic [CNT_WIDTH-1:0]    hit_cnt,
   output logic [CNT_WIDTH-1:0]    miss_cnt
);

   localparam int LOW_W = OFFSET_WIDTH + 2;

   state_e                  state_q, state_d;
   ctrl_t                   ctrl_q;
   logic [TAG_WIDTH-1:0]    req_tag_q, req_tag_d;
   logic [INDEX_WIDTH-1:0]  req_index_q, req_index_d;
   logic [OFFSET_WIDTH-1:0] req_word_q, req_word_d;
   logic                    req_we_q, req_we_d;
   logic [3:0]              req_be_q, req_be_d;
   logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
   logic [TAG_WIDTH-1:0]    victim_tag_q, victim_tag_d;
   logic [BLOCK_WIDTH-1:0]  victim_q, victim_d;
   logic [BLOCK_WIDTH-1:0]  fill_q, fill_d;
   logic                    lookup_hit;
   logic                    lookup_st;
   logic                    hit_inc;
   logic                    miss_inc;
   logic                    unused_addr_bits;

   assign lookup_hit       = line_hit & line_valid;
   assign lookup_st        = (state_q == COMPARE) || (state_q == REPLAY);
   assign unused_addr_bits = ^cpu_addr[1:0];

   always_comb begin
      state_d      = state_q;
      req_tag_d    = req_tag_q;
      req_index_d  = req_index_q;
      req_word_d   = req_word_q;
      req_we_d     = req_we_q;
      req_be_d     = req_be_q;
      req_wdata_d  = req_wdata_q;
      victim_tag_d = victim_tag_q;
      victim_d     = victim_q;
      fill_d       = fill_q;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               req_tag_d   = cpu_addr[31 -: TAG_WIDTH];
               req_index_d = cpu_addr[LOW_W +: INDEX_WIDTH];
               req_word_d  = cpu_addr[2 +: OFFSET_WIDTH];
               req_we_d    = cpu_we;
               req_be_d    = cpu_byte_en;
               req_wdata_d = cpu_wdata;
               state_d     = COMPARE;
            end
         end
         COMPARE: begin
            if (lookup_hit) begin
               hit_inc = 1'b1;
               state_d = IDLE;
            end else begin
               miss_inc = 1'b1;
               if (line_valid && line_dirty) begin
                  victim_d     = line_data_wb;
                  victim_tag_d = line_tag_out;
                  state_d      = WRITEBACK;
               end else begin
                  state_d = REFILL;
               end
            end
         end
         WRITEBACK: if (mem_ack) state_d = REFILL;
         REFILL: begin
            if (mem_ack) begin
               fill_d  = mem_rdata;
               state_d = INSTALL;
            end
         end
         INSTALL: state_d = REPLAY;
         // A fresh line always hits; the refill retry only guards against a misbehaving array.
         REPLAY: state_d = lookup_hit ? IDLE : REFILL;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ctrl_q       <= '0;
         req_tag_q    <= '0;
         req_index_q  <= '0;
         req_word_q   <= '0;
         req_we_q     <= 1'b0;
         req_be_q     <= '0;
         req_wdata_q  <= '0;
         victim_tag_q <= '0;
         victim_q     <= '0;
         fill_q       <= '0;
      end else begin
         state_q      <= state_d;
         ctrl_q       <= ctrl_for(state_d, req_we_d);
         req_tag_q    <= req_tag_d;
         req_index_q  <= req_index_d;
         req_word_q   <= req_word_d;
         req_we_q     <= req_we_d;
         req_be_q     <= req_be_d;
         req_wdata_q  <= req_wdata_d;
         victim_tag_q <= victim_tag_d;
         victim_q     <= victim_d;
         fill_q       <= fill_d;
      end
   end

   assign line_enable    = ctrl_q.enable;
   assign line_cmp       = ctrl_q.cmp;
   assign line_write     = ctrl_q.write;
   assign line_valid_in  = ctrl_q.valid_in;
   assign line_byte_w_en = req_be_q & {4{req_we_q}};
   assign line_tag       = req_tag_q;
   assign line_index     = req_index_q;
   assign line_word_sel  = req_word_q;
   assign line_data_in   = req_wdata_q;
   assign line_block_in  = fill_q;

   // Completion is combinational off the array so a hit finishes in the lookup cycle.
   assign cpu_ready = lookup_st & lookup_hit;
   assign cpu_rdata = cpu_ready ? line_data_out : '0;

   assign mem_req   = ctrl_q.mem_req;
   assign mem_we    = ctrl_q.mem_we;
   assign mem_wdata = victim_q;

   always_comb begin
      mem_addr = '0;
      if (state_q == WRITEBACK)
         mem_addr = {victim_tag_q, req_index_q, {LOW_W{1'b0}}};
      else if (state_q == REFILL)
         mem_addr = {req_tag_q, req_index_q, {LOW_W{1'b0}}};
   end

   cache_ctrl_perf #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_perf (
      .clk        (clk),
      .rst        (rst),
      .hit_inc_i  (hit_inc),
      .miss_inc_i (miss_inc),
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
   );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: behavioural line array, latency-programmable memory
// responder, a table of CPU accesses with hand-computed results, and reset/wrap sequences.
module tb_cache_ctrl_fsm;

   logic         clk;
   logic         rst;
   logic         cpu_req;
   logic         cpu_we;
   logic [31:0]  cpu_addr;
   logic [3:0]   cpu_byte_en;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata;
   logic         cpu_ready;
   logic         line_enable, line_cmp, line_write, line_valid_in;
   logic [3:0]   line_byte_w_en;
   logic [19:0]  line_tag;
   logic [6:0]   line_index;
   logic [2:0]   line_word_sel;
   logic [31:0]  line_data_in;
   logic [255:0] line_block_in;
   logic         line_hit, line_dirty, line_valid;
   logic [19:0]  line_tag_out;
   logic [31:0]  line_data_out;
   logic [255:0] line_data_wb;
   logic         mem_req, mem_we;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_ack;
   logic [15:0]  hit_cnt, miss_cnt;

   cache_ctrl_fsm dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_byte_en(cpu_byte_en),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .line_enable(line_enable), .line_cmp(line_cmp), .line_write(line_write),
      .line_valid_in(line_valid_in), .line_byte_w_en(line_byte_w_en), .line_tag(line_tag),
      .line_index(line_index), .line_word_sel(line_word_sel), .line_data_in(line_data_in),
      .line_block_in(line_block_in), .line_hit(line_hit), .line_dirty(line_dirty),
      .line_valid(line_valid), .line_tag_out(line_tag_out), .line_data_out(line_data_out),
      .line_data_wb(line_data_wb), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural one-line array; reinitialised whenever the controller is held in reset.
   logic        vld_m [128];
   logic        drt_m [128];
   logic [19:0] tag_m [128];
   logic [31:0] dat_m [128][8];

   always_comb begin
      line_data_wb  = '0;
      line_valid    = vld_m[line_index];
      line_dirty    = drt_m[line_index];
      line_tag_out  = tag_m[line_index];
      line_hit      = (tag_m[line_index] == line_tag);
      line_data_out = dat_m[line_index][line_word_sel];
      for (int i = 0; i < 8; i++) line_data_wb[i*32 +: 32] = dat_m[line_index][i];
   end

   always @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 128; s++) begin
            vld_m[s] <= 1'b0;
            drt_m[s] <= 1'b0;
            tag_m[s] <= '0;
            for (int w = 0; w < 8; w++) dat_m[s][w] <= '0;
         end
         vld_m[3] <= 1'b1;
         tag_m[3] <= 20'h12345;
         for (int w = 0; w < 8; w++) dat_m[3][w] <= 32'h3000_0000 + w;
      end else if (line_enable && line_write) begin
         if (line_cmp) begin
            if (tag_m[line_index] == line_tag) begin
               for (int b = 0; b < 4; b++)
                  if (line_byte_w_en[b])
                     dat_m[line_index][line_word_sel][b*8 +: 8] <= line_data_in[b*8 +: 8];
               drt_m[line_index] <= 1'b1;
            end
         end else begin
            vld_m[line_index] <= line_valid_in;
            drt_m[line_index] <= 1'b0;
            tag_m[line_index] <= line_tag;
            for (int w = 0; w < 8; w++) dat_m[line_index][w] <= line_block_in[w*32 +: 32];
         end
      end
   end

   // Memory responder: acks after a programmable number of request cycles.
   int           cur_wb_dly, cur_rf_dly, resp_cyc;
   logic [31:0]  cur_fill;
   logic         resp_en, late_ack;
   int           wb_seen, rf_seen, overlap_cnt;
   logic [31:0]  wb_addr_seen, rf_addr_seen;
   logic [255:0] wb_data_seen;

   always @(negedge clk) begin
      mem_ack = late_ack;
      if (cpu_ready && mem_req) overlap_cnt++;
      if (mem_req && resp_en) begin
         resp_cyc++;
         if (resp_cyc >= (mem_we ? cur_wb_dly : cur_rf_dly)) begin
            mem_ack  = 1'b1;
            resp_cyc = 0;
            if (mem_we) begin
               wb_seen++;
               wb_addr_seen = mem_addr;
               wb_data_seen = mem_wdata;
            end else begin
               rf_seen++;
               rf_addr_seen = mem_addr;
               for (int i = 0; i < 8; i++) mem_rdata[i*32 +: 32] = cur_fill + i;
            end
         end
      end else begin
         resp_cyc = 0;
      end
   end

   int pass_cnt, total_cnt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      string        name;
      logic         we;
      logic [31:0]  addr;
      logic [3:0]   be;
      logic [31:0]  wdata;
      int           wb_dly;
      int           rf_dly;
      logic [31:0]  fill;
      logic [31:0]  exp_rdata;
      int           exp_lat;
      int           exp_wb;
      logic [31:0]  exp_wb_addr;
      logic [255:0] exp_wb_blk;
      int           exp_rf;
      logic [31:0]  exp_rf_addr;
      logic [15:0]  exp_hits;
      logic [15:0]  exp_miss;
   } vec_t;

   function automatic vec_t mk(string n, logic we, logic [31:0] a, logic [3:0] be,
                               logic [31:0] wd, int wbd, int rfd, logic [31:0] fill,
                               logic [31:0] rd, int lat, int ewb, logic [31:0] wba,
                               logic [255:0] wbb, int erf, logic [31:0] rfa,
                               logic [15:0] h, logic [15:0] m);
      vec_t v;
      v.name = n; v.we = we; v.addr = a; v.be = be; v.wdata = wd;
      v.wb_dly = wbd; v.rf_dly = rfd; v.fill = fill; v.exp_rdata = rd; v.exp_lat = lat;
      v.exp_wb = ewb; v.exp_wb_addr = wba; v.exp_wb_blk = wbb;
      v.exp_rf = erf; v.exp_rf_addr = rfa; v.exp_hits = h; v.exp_miss = m;
      return v;
   endfunction

   task automatic do_req(input vec_t v);
      int   lat, wb0, rf0;
      logic got;
      logic [31:0] rd;
      cur_wb_dly = v.wb_dly;
      cur_rf_dly = v.rf_dly;
      cur_fill   = v.fill;
      wb0 = wb_seen;
      rf0 = rf_seen;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_byte_en = v.be; cpu_wdata = v.wdata;
      @(posedge clk);
      #1;
      cpu_req = 1'b0; cpu_we = ~v.we; cpu_addr = 32'hFFFF_FFFF; cpu_byte_en = 4'hF;
      cpu_wdata = 32'h5A5A_5A5A;
      lat = 0; got = 1'b0; rd = '0;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         if (cpu_ready) begin
            got = 1'b1;
            rd  = cpu_rdata;
         end
      end
      chk({v.name, "_done"}, 64'(got), 64'd1);
      chk({v.name, "_lat"}, 64'(lat), 64'(v.exp_lat));
      if (!v.we) chk({v.name, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
      chk({v.name, "_wb_cnt"}, 64'(wb_seen - wb0), 64'(v.exp_wb));
      if (v.exp_wb != 0) begin
         chk({v.name, "_wb_addr"}, 64'(wb_addr_seen), 64'(v.exp_wb_addr));
         for (int i = 0; i < 8; i++)
            chk({v.name, "_wb_word"}, 64'(wb_data_seen[i*32 +: 32]), 64'(v.exp_wb_blk[i*32 +: 32]));
      end
      chk({v.name, "_rf_cnt"}, 64'(rf_seen - rf0), 64'(v.exp_rf));
      if (v.exp_rf != 0) chk({v.name, "_rf_addr"}, 64'(rf_addr_seen), 64'(v.exp_rf_addr));
      @(negedge clk);
      chk({v.name, "_hit_cnt"}, 64'(hit_cnt), 64'(v.exp_hits));
      chk({v.name, "_miss_cnt"}, 64'(miss_cnt), 64'(v.exp_miss));
   endtask

   vec_t         vecs[$];
   logic [255:0] old_blk;
   int           k;

   initial begin
      clk = 1'b0; rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
      cpu_byte_en = '0; cpu_wdata = '0; resp_en = 1'b1; late_ack = 1'b0;
      cur_wb_dly = 1; cur_rf_dly = 1; cur_fill = '0;
      pass_cnt = 0; total_cnt = 0; wb_seen = 0; rf_seen = 0; overlap_cnt = 0; resp_cyc = 0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_line_enable", 64'(line_enable), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
      chk("rst_line_tag", 64'(line_tag), 64'd0);
      chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Block evicted by the dirty miss: refill pattern plus the byte-3 store on word 0.
      for (int i = 0; i < 8; i++) old_blk[i*32 +: 32] = 32'hCAFE_F00D + i;
      old_blk[31:0] = 32'hABFE_F00D;

      vecs.push_back(mk("rd_hit", 0, 32'h1234_5064, 4'h0, 0, 1, 1, 0,
                        32'h3000_0001, 1, 0, 0, '0, 0, 0, 16'd1, 16'd0));
      vecs.push_back(mk("rd_clean_miss", 0, 32'h0000_1020, 4'h0, 0, 1, 5, 32'hCAFE_F00D,
                        32'hCAFE_F00D, 8, 0, 0, '0, 1, 32'h0000_1020, 16'd1, 16'd1));
      vecs.push_back(mk("wr_hit_b3", 1, 32'h0000_1020, 4'b1000, 32'hAB00_0000, 1, 1, 0,
                        0, 1, 0, 0, '0, 0, 0, 16'd2, 16'd1));
      vecs.push_back(mk("rd_after_wr", 0, 32'h0000_1020, 4'h0, 0, 1, 1, 0,
                        32'hABFE_F00D, 1, 0, 0, '0, 0, 0, 16'd3, 16'd1));
      vecs.push_back(mk("wr_dirty_miss", 1, 32'h0000_2024, 4'b0011, 32'h1234_5678, 3, 4,
                        32'h5000_0000, 0, 10, 1, 32'h0000_1020, old_blk, 1, 32'h0000_2020,
                        16'd3, 16'd2));
      vecs.push_back(mk("rd_merged", 0, 32'h0000_2024, 4'h0, 0, 1, 1, 0,
                        32'h5000_5678, 1, 0, 0, '0, 0, 0, 16'd4, 16'd2));
      vecs.push_back(mk("rd_inv_tagmatch", 0, 32'h0000_00A8, 4'h0, 0, 1, 1, 32'h7700_0000,
                        32'h7700_0002, 4, 0, 0, '0, 1, 32'h0000_00A0, 16'd4, 16'd3));
      vecs.push_back(mk("wr_clean_miss", 1, 32'h0000_00C4, 4'hF, 32'hDEAD_BEEF, 1, 2,
                        32'h6600_0000, 0, 5, 0, 0, '0, 1, 32'h0000_00C0, 16'd4, 16'd4));
      vecs.push_back(mk("rd_replayed_wr", 0, 32'h0000_00C4, 4'h0, 0, 1, 1, 0,
                        32'hDEAD_BEEF, 1, 0, 0, '0, 0, 0, 16'd5, 16'd4));

      foreach (vecs[i]) do_req(vecs[i]);

      chk("line1_dirty", 64'(drt_m[1]), 64'd1);
      chk("line1_tag", 64'(tag_m[1]), 64'h2);
      chk("line1_word1", 64'(dat_m[1][1]), 64'h5000_5678);
      chk("line6_dirty", 64'(drt_m[6]), 64'd1);

      // Reset while a refill is outstanding.
      resp_en = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4000; cpu_byte_en = 4'h0;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      k = 0;
      while (!mem_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("midrefill_mem_req", 64'(mem_req), 64'd1);
      chk("midrefill_mem_addr", 64'(mem_addr), 64'h0000_4000);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrefill_req_drop", 64'(mem_req), 64'd0);
      chk("midrefill_addr_clr", 64'(mem_addr), 64'd0);
      chk("midrefill_miss_clr", 64'(miss_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #2 late_ack = 1'b1;
      @(negedge clk);
      #2 late_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("late_ack_mem_req", 64'(mem_req), 64'd0);
      chk("late_ack_line_en", 64'(line_enable), 64'd0);
      resp_en = 1'b1;
      do_req(mk("post_rst_hit", 0, 32'h1234_5068, 4'h0, 0, 1, 1, 0,
                32'h3000_0002, 1, 0, 0, '0, 0, 0, 16'd1, 16'd0));

      // Miss counter wrap.
      @(negedge clk);
      force dut.u_perf.miss_q = 16'hFFFF;
      #1 release dut.u_perf.miss_q;
      #1 chk("wrap_preload", 64'(miss_cnt), 64'hFFFF);
      do_req(mk("wrap_miss", 0, 32'h0000_4000, 4'h0, 0, 1, 2, 32'h4040_0000,
                32'h4040_0000, 5, 0, 0, '0, 1, 32'h0000_4000, 16'd1, 16'd0));

      chk("ready_with_mem_req", 64'(overlap_cnt), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
